leitor_digito_agro: RTL and testbench

- Self-check receiver for the rotating single-digit 7-segment display driven by the mod-6 digit counter.
- Samples the 7-bit segment bus each clock, filters glitches with a stability window and decodes the pattern back to the 0..5 counter state.
- Checks that accepted states advance strictly in counter order and counts full rotations.
- Sits beside the display driver; its outputs feed the fault/status logic.

---
 rtl/leitor_digito_agro_pkg.sv | 42 ++++
 rtl/leitor_digito_agro_filtro_estavel.sv | 45 ++++
 rtl/leitor_digito_agro.sv | 109 ++++++++++
 tb/tb_leitor_digito_agro.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/leitor_digito_agro_pkg.sv
// Shared code table for the mod-6 digit display: state patterns, blank code and decoder.
// Used by both the display driver and its self-check receiver.
package leitor_digito_agro_pkg;

    localparam int N_ESTADOS = 6;

    // Patterns written as {g..a}: segment g lit plus exactly one outer segment.
    localparam logic [6:0] COD_0     = 7'h42;
    localparam logic [6:0] COD_1     = 7'h44;
    localparam logic [6:0] COD_2     = 7'h48;
    localparam logic [6:0] COD_3     = 7'h50;
    localparam logic [6:0] COD_4     = 7'h60;
    localparam logic [6:0] COD_5     = 7'h41;
    localparam logic [6:0] COD_BLANK = 7'h40;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [2:0] k;
    } dec_t;

    function automatic dec_t decodifica(input logic [6:0] seg);
        dec_t r;
        r = '0;
        case (seg)
            COD_0:     begin r.legal = 1'b1; r.k = 3'd0; end
            COD_1:     begin r.legal = 1'b1; r.k = 3'd1; end
            COD_2:     begin r.legal = 1'b1; r.k = 3'd2; end
            COD_3:     begin r.legal = 1'b1; r.k = 3'd3; end
            COD_4:     begin r.legal = 1'b1; r.k = 3'd4; end
            COD_5:     begin r.legal = 1'b1; r.k = 3'd5; end
            COD_BLANK: r.blank = 1'b1;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] proximo(input logic [2:0] k);
        return (k == 3'(N_ESTADOS - 1)) ? 3'd0 : k + 3'd1;
    endfunction

endpackage

// File: rtl/leitor_digito_agro_filtro_estavel.sv
// Stability filter: a candidate value is reported stable once it has been seen
// STABLE_CYCLES consecutive samples. Outputs reflect the state being loaded this edge.
module filtro_estavel #(
    parameter int W             = 7,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         stable
);

    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    logic [W-1:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (din != cand_q) begin
            cand_d = din;
            cnt_d  = CW'(1);
        end else if (cnt_q < CMAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Look-ahead so acceptance lands on the same edge the count reaches the window.
    assign dout   = cand_d;
    assign stable = (cnt_d == CMAX);

endmodule

// File: rtl/leitor_digito_agro.sv
// Self-check receiver for the rotating 7-segment digit: filters the bus, decodes it
// back to the 0..5 counter state, checks ordering and counts full rotations.
module leitor_digito_agro
    import leitor_digito_agro_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int WRAP_W        = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [6:0]        segmentos,
    output logic [2:0]        digito,
    output logic              digito_valido,
    output logic              novo,
    output logic              erro_codigo,
    output logic              erro_sequencia,
    output logic [WRAP_W-1:0] voltas
);

    logic [6:0]        s_q;
    logic [6:0]        cand;
    logic              stable;
    logic [6:0]        aceito_q, aceito_d;
    logic [2:0]        digito_q, digito_d;
    logic              valido_q, valido_d;
    logic              novo_q, novo_d;
    logic              cod_q, cod_d;
    logic              seq_q, seq_d;
    logic [WRAP_W-1:0] voltas_q, voltas_d;
    logic [2:0]        prev_q, prev_d;
    logic              hist_q, hist_d;
    logic              aceita;
    dec_t              dec;

    filtro_estavel #(.W(7), .STABLE_CYCLES(STABLE_CYCLES)) u_filtro (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (s_q),
        .dout    (cand),
        .stable  (stable)
    );

    assign dec    = decodifica(cand);
    assign aceita = stable && (cand != aceito_q);

    always_comb begin
        aceito_d = aceito_q;
        digito_d = digito_q;
        valido_d = valido_q;
        novo_d   = 1'b0;
        cod_d    = 1'b0;
        seq_d    = 1'b0;
        voltas_d = voltas_q;
        prev_d   = prev_q;
        hist_d   = hist_q;
        if (aceita) begin
            aceito_d = cand;
            if (dec.legal) begin
                digito_d = dec.k;
                valido_d = 1'b1;
                novo_d   = 1'b1;
                seq_d    = hist_q && (dec.k != proximo(prev_q));
                if (hist_q && prev_q == 3'd5 && dec.k == 3'd0 && voltas_q != '1)
                    voltas_d = voltas_q + WRAP_W'(1);
                prev_d   = dec.k;
                hist_d   = 1'b1;
            end else begin
                // Blank and illegal both break the history; only illegal is an error.
                valido_d = 1'b0;
                hist_d   = 1'b0;
                cod_d    = !dec.blank;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_q      <= '0;
            aceito_q <= '0;
            digito_q <= '0;
            valido_q <= 1'b0;
            novo_q   <= 1'b0;
            cod_q    <= 1'b0;
            seq_q    <= 1'b0;
            voltas_q <= '0;
            prev_q   <= '0;
            hist_q   <= 1'b0;
        end else begin
            s_q      <= segmentos;
            aceito_q <= aceito_d;
            digito_q <= digito_d;
            valido_q <= valido_d;
            novo_q   <= novo_d;
            cod_q    <= cod_d;
            seq_q    <= seq_d;
            voltas_q <= voltas_d;
            prev_q   <= prev_d;
            hist_q   <= hist_d;
        end
    end

    assign digito         = digito_q;
    assign digito_valido  = valido_q;
    assign novo           = novo_q;
    assign erro_codigo    = cod_q;
    assign erro_sequencia = seq_q;
    assign voltas         = voltas_q;

endmodule

// File: tb/tb_leitor_digito_agro.sv
// Directed bench for leitor_digito_agro: default instance plus a STABLE_CYCLES=1,
// WRAP_W=2 instance sharing the same bus.
module tb_leitor_digito_agro;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] segmentos = 7'h00;

    logic [2:0] digito, s_digito;
    logic       digito_valido, s_valido;
    logic       novo, s_novo;
    logic       erro_codigo, s_cod;
    logic       erro_sequencia, s_seq;
    logic [7:0] voltas;
    logic [1:0] s_voltas;

    int tests_run = 0;
    int tests_failed = 0;
    int n_novo, n_cod, n_seq, at_novo, at_cod, at_seq, at_novo2;

    always #5 clock = ~clock;

    leitor_digito_agro u_dut (
        .clock(clock), .reset_n(reset_n), .segmentos(segmentos),
        .digito(digito), .digito_valido(digito_valido), .novo(novo),
        .erro_codigo(erro_codigo), .erro_sequencia(erro_sequencia), .voltas(voltas)
    );

    leitor_digito_agro #(.STABLE_CYCLES(1), .WRAP_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n), .segmentos(segmentos),
        .digito(s_digito), .digito_valido(s_valido), .novo(s_novo),
        .erro_codigo(s_cod), .erro_sequencia(s_seq), .voltas(s_voltas)
    );

    // Drive a pattern at a falling edge and observe n cycles; records pulse counts
    // and the first cycle (1-based) each pulse appeared, 0 if never.
    task automatic hold(input logic [6:0] pat, input int n);
        n_novo = 0; n_cod = 0; n_seq = 0;
        at_novo = 0; at_cod = 0; at_seq = 0; at_novo2 = 0;
        segmentos = pat;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (novo) begin n_novo++; if (at_novo == 0) at_novo = i; end
            if (erro_codigo) begin n_cod++; if (at_cod == 0) at_cod = i; end
            if (erro_sequencia) begin n_seq++; if (at_seq == 0) at_seq = i; end
            if (s_novo && at_novo2 == 0) at_novo2 = i;
        end
    endtask

    task automatic test_reset();
        #3;
        tests_run++; if ({digito, digito_valido, novo, erro_codigo, erro_sequencia, voltas} !== 15'd0) begin tests_failed++; $display("FAIL reset_in outputs=%h expected 0", {digito, digito_valido, novo, erro_codigo, erro_sequencia, voltas}); end
        tests_run++; if (s_voltas !== 2'd0 || s_novo !== 1'b0) begin tests_failed++; $display("FAIL reset_in_sat voltas=%0d novo=%b expected 0 0", s_voltas, s_novo); end
        @(negedge clock);
        reset_n = 1'b1;
        hold(7'h00, 20);
        tests_run++; if (n_novo + n_cod + n_seq !== 0) begin tests_failed++; $display("FAIL reset_dark pulses=%0d expected 0", n_novo + n_cod + n_seq); end
        tests_run++; if ({digito, digito_valido, voltas} !== 12'd0) begin tests_failed++; $display("FAIL reset_dark_out got=%h expected 0", {digito, digito_valido, voltas}); end
    endtask

    task automatic test_rotation();
        logic [6:0] codes [7] = '{7'h42, 7'h44, 7'h48, 7'h50, 7'h60, 7'h41, 7'h42};
        logic [2:0] exp_d [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int j = 0; j < 7; j++) begin
            hold(codes[j], 8);
            tests_run++; if (n_novo !== 1 || at_novo !== 5) begin tests_failed++; $display("FAIL rot_novo[%0d] count=%0d at=%0d expected 1 at 5", j, n_novo, at_novo); end
            tests_run++; if (n_cod !== 0 || n_seq !== 0) begin tests_failed++; $display("FAIL rot_err[%0d] cod=%0d seq=%0d expected 0 0", j, n_cod, n_seq); end
            tests_run++; if (digito !== exp_d[j] || digito_valido !== 1'b1) begin tests_failed++; $display("FAIL rot_digito[%0d] got=%0d/%b expected %0d/1", j, digito, digito_valido, exp_d[j]); end
        end
        tests_run++; if (voltas !== 8'd1) begin tests_failed++; $display("FAIL rot_voltas got=%0d expected 1", voltas); end
    endtask

    task automatic test_glitch();
        hold(7'h44, 8);
        tests_run++; if (n_novo !== 1 || digito !== 3'd1) begin tests_failed++; $display("FAIL glitch_setup novo=%0d digito=%0d expected 1 1", n_novo, digito); end
        hold(7'h48, 3);
        tests_run++; if (n_novo + n_cod + n_seq !== 0) begin tests_failed++; $display("FAIL glitch_short pulses=%0d expected 0", n_novo + n_cod + n_seq); end
        hold(7'h44, 8);
        tests_run++; if (n_novo + n_cod + n_seq !== 0 || digito !== 3'd1) begin tests_failed++; $display("FAIL glitch_return pulses=%0d digito=%0d expected 0 1", n_novo + n_cod + n_seq, digito); end
    endtask

    task automatic test_sequence();
        hold(7'h40, 8);
        tests_run++; if (n_novo + n_cod + n_seq !== 0 || digito_valido !== 1'b0 || digito !== 3'd1) begin tests_failed++; $display("FAIL blank pulses=%0d valid=%b digito=%0d expected 0 0 1", n_novo + n_cod + n_seq, digito_valido, digito); end
        hold(7'h42, 8);
        tests_run++; if (n_novo !== 1 || n_seq !== 0 || digito !== 3'd0) begin tests_failed++; $display("FAIL seq_first novo=%0d seq=%0d digito=%0d expected 1 0 0", n_novo, n_seq, digito); end
        hold(7'h48, 8);
        tests_run++; if (n_seq !== 1 || at_seq !== at_novo || at_novo !== 5 || digito !== 3'd2) begin tests_failed++; $display("FAIL seq_skip seq=%0d at_seq=%0d at_novo=%0d digito=%0d expected 1 5 5 2", n_seq, at_seq, at_novo, digito); end
        hold(7'h50, 8);
        tests_run++; if (n_novo !== 1 || n_seq !== 0 || digito !== 3'd3) begin tests_failed++; $display("FAIL seq_resume novo=%0d seq=%0d digito=%0d expected 1 0 3", n_novo, n_seq, digito); end
    endtask

    task automatic test_illegal();
        hold(7'h4C, 6);
        tests_run++; if (n_cod !== 1 || at_cod !== 5 || n_novo !== 0) begin tests_failed++; $display("FAIL illegal_pulse cod=%0d at=%0d novo=%0d expected 1 5 0", n_cod, at_cod, n_novo); end
        tests_run++; if (digito_valido !== 1'b0 || digito !== 3'd3) begin tests_failed++; $display("FAIL illegal_hold valid=%b digito=%0d expected 0 3", digito_valido, digito); end
        hold(7'h44, 8);
        tests_run++; if (n_novo !== 1 || n_seq !== 0 || n_cod !== 0 || digito !== 3'd1 || digito_valido !== 1'b1) begin tests_failed++; $display("FAIL illegal_recover novo=%0d seq=%0d cod=%0d digito=%0d valid=%b expected 1 0 0 1 1", n_novo, n_seq, n_cod, digito, digito_valido); end
    endtask

    task automatic test_saturation();
        logic [6:0] codes [6] = '{7'h42, 7'h44, 7'h48, 7'h50, 7'h60, 7'h41};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 6; j++) hold(codes[j], 6);
        hold(7'h42, 6);
        tests_run++; if (s_voltas !== 2'd3) begin tests_failed++; $display("FAIL sat_voltas got=%0d expected 3", s_voltas); end
        tests_run++; if (voltas !== 8'd5) begin tests_failed++; $display("FAIL wide_voltas got=%0d expected 5", voltas); end
    endtask

    task automatic test_stable1();
        hold(7'h44, 8);
        tests_run++; if (at_novo2 !== 2 || s_digito !== 3'd1) begin tests_failed++; $display("FAIL stable1_latency at=%0d digito=%0d expected 2 1", at_novo2, s_digito); end
        tests_run++; if (at_novo !== 5 || n_seq !== 0) begin tests_failed++; $display("FAIL default_latency at=%0d seq=%0d expected 5 0", at_novo, n_seq); end
    endtask

    task automatic test_reset_mid();
        segmentos = 7'h48;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if ({digito, digito_valido, novo, erro_codigo, erro_sequencia, voltas} !== 15'd0) begin tests_failed++; $display("FAIL reset_mid outputs=%h expected 0", {digito, digito_valido, novo, erro_codigo, erro_sequencia, voltas}); end
        tests_run++; if (s_voltas !== 2'd0 || s_digito !== 3'd0) begin tests_failed++; $display("FAIL reset_mid_sat voltas=%0d digito=%0d expected 0 0", s_voltas, s_digito); end
        @(negedge clock);
        reset_n = 1'b1;
        hold(7'h48, 8);
        tests_run++; if (n_novo !== 1 || at_novo !== 5 || n_seq !== 0 || digito !== 3'd2) begin tests_failed++; $display("FAIL reset_after novo=%0d at=%0d seq=%0d digito=%0d expected 1 5 0 2", n_novo, at_novo, n_seq, digito); end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_glitch();
        test_sequence();
        test_illegal();
        test_saturation();
        test_stable1();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
